// File: rtl/rx_frame_buffer_pkg.sv
// Shared definitions for the receive frame buffer: write FSM encoding and
// default frame-length limits.
package rx_frame_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2
  } wr_state_e;

  localparam int DEF_MIN_LEN = 60;
  localparam int DEF_MAX_LEN = 1514;
  localparam int LEN_W       = 11;

endpackage

// File: rtl/rx_buf_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port.
// The read register holds its value when rd_en is low.
module rx_buf_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/rx_frame_buffer.sv
// Store-and-forward receive buffer: frames from the MAC are written into a
// circular RAM and only released to the consumer once committed as good.
module rx_frame_buffer
  import rx_frame_buffer_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int MIN_LEN = DEF_MIN_LEN,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = 16
) (
  input  logic             rx_mac_clk,
  input  logic             reset,
  input  logic             rx_mac_valid,
  input  logic [7:0]       rx_mac_data,
  input  logic             rx_mac_last,
  input  logic             rx_mac_err,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             drop_pulse,
  output logic [CNT_W-1:0] frames_ok,
  output logic [CNT_W-1:0] frames_drop
);

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  wr_state_e         state_reg, state_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  commit_ptr_reg, commit_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [LEN_W-1:0]  len_reg, len_next, len_inc;
  logic              drop_pulse_reg, drop_pulse_next;
  logic              ok_inc, drop_inc, wr_en;
  logic [CNT_W-1:0]  frames_ok_reg, frames_drop_reg;

  logic              full, empty;
  logic              slot_open, fetch, load;
  logic              ram_vld_reg;
  logic [8:0]        ram_rd_data;
  logic              out_valid_reg, out_last_reg;
  logic [7:0]        out_data_reg;

  assign full  = (wr_ptr_reg - rd_ptr_reg) == DEPTH;
  assign empty = (rd_ptr_reg == commit_ptr_reg);

  // Length including the byte presented this cycle, saturating at MAX_LEN+1.
  assign len_inc = (state_reg == ST_IDLE) ? LEN_ONE :
                   (len_reg == LEN_SAT)   ? LEN_SAT : len_reg + LEN_ONE;

  always_comb begin
    state_next      = state_reg;
    wr_ptr_next     = wr_ptr_reg;
    commit_ptr_next = commit_ptr_reg;
    len_next        = len_reg;
    drop_pulse_next = 1'b0;
    ok_inc          = 1'b0;
    drop_inc        = 1'b0;
    wr_en           = 1'b0;
    case (state_reg)
      ST_IDLE, ST_RECV: begin
        if (rx_mac_valid) begin
          if (full) begin
            wr_ptr_next = commit_ptr_reg;
            if (rx_mac_last) begin
              drop_pulse_next = 1'b1;
              drop_inc        = 1'b1;
              state_next      = ST_IDLE;
            end else begin
              state_next = ST_DISCARD;
            end
          end else begin
            wr_en    = 1'b1;
            len_next = len_inc;
            if (rx_mac_last) begin
              if (!rx_mac_err && len_inc >= LEN_MIN && len_inc <= LEN_MAX) begin
                wr_ptr_next     = wr_ptr_reg + PTR_ONE;
                commit_ptr_next = wr_ptr_reg + PTR_ONE;
                ok_inc          = 1'b1;
              end else begin
                wr_ptr_next     = commit_ptr_reg;
                drop_pulse_next = 1'b1;
                drop_inc        = 1'b1;
              end
              state_next = ST_IDLE;
            end else if (len_inc > LEN_MAX) begin
              wr_ptr_next = commit_ptr_reg;
              state_next  = ST_DISCARD;
            end else begin
              wr_ptr_next = wr_ptr_reg + PTR_ONE;
              state_next  = ST_RECV;
            end
          end
        end
      end
      ST_DISCARD: begin
        if (rx_mac_valid && rx_mac_last) begin
          drop_pulse_next = 1'b1;
          drop_inc        = 1'b1;
          state_next      = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge rx_mac_clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      wr_ptr_reg      <= '0;
      commit_ptr_reg  <= '0;
      len_reg         <= '0;
      drop_pulse_reg  <= 1'b0;
      frames_ok_reg   <= '0;
      frames_drop_reg <= '0;
    end else begin
      state_reg      <= state_next;
      wr_ptr_reg     <= wr_ptr_next;
      commit_ptr_reg <= commit_ptr_next;
      len_reg        <= len_next;
      drop_pulse_reg <= drop_pulse_next;
      if (ok_inc && frames_ok_reg != CNT_MAX) begin
        frames_ok_reg <= frames_ok_reg + CNT_ONE;
      end
      if (drop_inc && frames_drop_reg != CNT_MAX) begin
        frames_drop_reg <= frames_drop_reg + CNT_ONE;
      end
    end
  end

  // Read pipeline: RAM read register, then the output register. The RAM stage
  // frees up exactly when the output stage can accept, so one condition gates both.
  assign slot_open = !out_valid_reg || out_ready;
  assign fetch     = !empty && slot_open;
  assign load      = ram_vld_reg && slot_open;

  rx_buf_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (9)
  ) u_ram (
    .clk     (rx_mac_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_reg[ADDR_W-1:0]),
    .wr_data ({rx_mac_last, rx_mac_data}),
    .rd_en   (fetch),
    .rd_addr (rd_ptr_reg[ADDR_W-1:0]),
    .rd_data (ram_rd_data)
  );

  always_ff @(posedge rx_mac_clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg    <= '0;
      ram_vld_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      if (fetch) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      ram_vld_reg <= fetch || (ram_vld_reg && !slot_open);
      if (load) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= ram_rd_data[7:0];
        out_last_reg  <= ram_rd_data[8];
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_data    = out_data_reg;
  assign out_last    = out_last_reg;
  assign drop_pulse  = drop_pulse_reg;
  assign frames_ok   = frames_ok_reg;
  assign frames_drop = frames_drop_reg;

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Self-checking bench for rx_frame_buffer: frame table, scoreboard of
// expected output bytes, and hand-written overflow / stall / reset sequences.
module tb_rx_frame_buffer;

  localparam int CNT_W = 16;

  logic             rx_mac_clk = 1'b0;
  logic             reset;
  logic             rx_mac_valid = 1'b0;
  logic [7:0]       rx_mac_data = '0;
  logic             rx_mac_last = 1'b0;
  logic             rx_mac_err = 1'b0;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_last;
  logic             out_ready;
  logic             drop_pulse;
  logic [CNT_W-1:0] frames_ok;
  logic [CNT_W-1:0] frames_drop;

  logic ready_ctl = 1'b0;
  logic rand_mode = 1'b0;
  logic rand_bit  = 1'b1;
  assign out_ready = rand_mode ? rand_bit : ready_ctl;

  always #5 rx_mac_clk = ~rx_mac_clk;

  rx_frame_buffer dut (
    .rx_mac_clk   (rx_mac_clk),
    .reset        (reset),
    .rx_mac_valid (rx_mac_valid),
    .rx_mac_data  (rx_mac_data),
    .rx_mac_last  (rx_mac_last),
    .rx_mac_err   (rx_mac_err),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .drop_pulse   (drop_pulse),
    .frames_ok    (frames_ok),
    .frames_drop  (frames_drop)
  );

  int         tests_run = 0;
  int         fails = 0;
  int         drop_seen = 0;
  int         ok_exp = 0;
  int         drop_exp = 0;
  logic [8:0] exp_q [$];
  logic       prev_stall = 1'b0;
  logic [8:0] prev_word = '0;

  typedef struct {
    int len;
    bit err;
    bit commit;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge rx_mac_clk) begin
    #1;
    rand_bit = ($urandom_range(0, 3) != 0);
  end

  // Output monitor: pops the scoreboard on each accepted byte, checks stall hold.
  always @(negedge rx_mac_clk) begin
    if (reset) begin
      if (drop_pulse) drop_seen++;
      if (prev_stall) begin
        check("stall_hold", {23'd0, out_valid, out_last, out_data}, {23'd0, 1'b1, prev_word});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          fails++;
          $display("[TB] FAIL unexpected_byte: got %h, expected no output", {out_last, out_data});
        end else begin
          check("out_byte", {23'd0, out_last, out_data}, {23'd0, exp_q.pop_front()});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge rx_mac_clk);
    #1;
  endtask

  task automatic send_frame(input int len, input bit err, input bit expect_ok);
    logic [8:0] w;
    for (int i = 0; i < len; i++) begin
      w = {(i == len - 1), 8'($urandom)};
      rx_mac_valid = 1'b1;
      rx_mac_data  = w[7:0];
      rx_mac_last  = w[8];
      rx_mac_err   = err && w[8];
      if (expect_ok) exp_q.push_back(w);
      step();
    end
    rx_mac_valid = 1'b0;
    rx_mac_last  = 1'b0;
    rx_mac_err   = 1'b0;
    rx_mac_data  = '0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      step();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frames_ok"}, 32'(frames_ok), ok_exp);
    check({tag, "_frames_drop"}, 32'(frames_drop), drop_exp);
  endtask

  initial begin
    int d0;
    int n;
    int len;

    vecs[0] = '{len: 64,   err: 1'b1, commit: 1'b0};
    vecs[1] = '{len: 40,   err: 1'b0, commit: 1'b0};
    vecs[2] = '{len: 1600, err: 1'b0, commit: 1'b0};
    vecs[3] = '{len: 100,  err: 1'b0, commit: 1'b1};
    vecs[4] = '{len: 60,   err: 1'b0, commit: 1'b1};
    vecs[5] = '{len: 59,   err: 1'b0, commit: 1'b0};
    vecs[6] = '{len: 1514, err: 1'b0, commit: 1'b1};
    vecs[7] = '{len: 1515, err: 1'b0, commit: 1'b0};
    vecs[8] = '{len: 1,    err: 1'b0, commit: 1'b0};
    vecs[9] = '{len: 61,   err: 1'b1, commit: 1'b0};

    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge rx_mac_clk);
    @(negedge rx_mac_clk);
    check("reset_outputs", {out_valid, out_last, out_data, drop_pulse}, '0);
    check("reset_counters", {frames_ok, frames_drop}, '0);
    @(posedge rx_mac_clk);
    #1 reset = 1'b1;
    ready_ctl = 1'b1;
    step();

    // 64-byte good frame with commit-to-output latency.
    send_frame(64, 1'b0, 1'b1);
    ok_exp++;
    @(negedge rx_mac_clk);
    check("lat_commit_cycle", out_valid, 0);
    @(posedge rx_mac_clk);
    @(negedge rx_mac_clk);
    check("lat_plus1", out_valid, 0);
    @(posedge rx_mac_clk);
    @(negedge rx_mac_clk);
    check("lat_plus2", out_valid, 1);
    step();
    wait_drain("t1_drain", 200);
    check_counts("t1");

    for (int v = 0; v < 10; v++) begin
      d0 = drop_seen;
      send_frame(vecs[v].len, vecs[v].err, vecs[v].commit);
      if (vecs[v].commit) ok_exp++;
      else drop_exp++;
      repeat (3) step();
      wait_drain("vec_drain", 4000);
      check_counts($sformatf("vec%0d", v));
      check($sformatf("vec%0d_drop_pulses", v), drop_seen - d0, vecs[v].commit ? 0 : 1);
    end

    // Overflow: consumer stalled while two 1500-byte frames arrive.
    ready_ctl = 1'b0;
    d0 = drop_seen;
    send_frame(1500, 1'b0, 1'b1);
    send_frame(1500, 1'b0, 1'b0);
    ok_exp++;
    drop_exp++;
    repeat (3) step();
    check_counts("t4");
    check("t4_drop_pulses", drop_seen - d0, 1);
    check("t4_head_waiting", out_valid, 1);
    ready_ctl = 1'b1;
    wait_drain("t4_drain", 4000);
    send_frame(80, 1'b0, 1'b1);
    ok_exp++;
    wait_drain("t4_after", 400);
    check_counts("t4_after");

    // Random consumer backpressure over 20 frames.
    rand_mode = 1'b1;
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(60, 1514);
      n = 0;
      while (exp_q.size() + len > 1900 && n < 20000) begin
        step();
        n++;
      end
      check("t5_throttle", (exp_q.size() + len <= 1900), 1);
      send_frame(len, 1'b0, 1'b1);
      ok_exp++;
    end
    wait_drain("t5_drain", 20000);
    rand_mode = 1'b0;
    repeat (2) step();
    check_counts("t5");

    // Reset pulse mid-output.
    ready_ctl = 1'b1;
    send_frame(300, 1'b0, 1'b1);
    n = 0;
    while (exp_q.size() > 200 && n < 1000) begin
      step();
      n++;
    end
    check("t6_mid_output", out_valid, 1);
    reset = 1'b0;
    @(negedge rx_mac_clk);
    check("t6_reset_outputs", {out_valid, out_last, out_data, drop_pulse}, '0);
    check("t6_reset_counters", {frames_ok, frames_drop}, '0);
    exp_q.delete();
    ok_exp = 0;
    drop_exp = 0;
    @(posedge rx_mac_clk);
    #1 reset = 1'b1;
    step();
    check("t6_idle_after", out_valid, 0);
    send_frame(70, 1'b0, 1'b1);
    ok_exp++;
    wait_drain("t6_drain", 400);
    repeat (2) step();
    check_counts("t6");

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
